// File: rtl/can_rx_frame_engine_if.sv
// can_rx_frame_engine_if
//   Delivery bundle between the CAN receive engine and the RX message buffer.
//   The engine (master) presents a held frame with rx_valid; the consumer
//   (slave) accepts it with rx_ready.
//
//   rx_valid       master->slave  held frame available
//   rx_ready       slave->master  consumer accepts held frame
//   rx_id_std      master->slave  11-bit base identifier
//   rx_id_ext      master->slave  18-bit extension identifier (0 for base frames)
//   rx_ide         master->slave  extended frame
//   rx_remote_req  master->slave  remote frame
//   rx_dlc         master->slave  raw DLC
//   rx_data        master->slave  byte k at [8k+7:8k], unreceived bytes 0
//   rx_filter_idx  master->slave  lowest matching filter, all-ones = accept-all
interface can_rx_frame_engine_if #(
  parameter int MAX_BYTES   = 8,
  parameter int NUM_FILTERS = 4
);
  localparam int FIDX_W = $clog2(NUM_FILTERS) + 1;

  logic                   rx_valid;
  logic                   rx_ready;
  logic [10:0]            rx_id_std;
  logic [17:0]            rx_id_ext;
  logic                   rx_ide;
  logic                   rx_remote_req;
  logic [3:0]             rx_dlc;
  logic [8*MAX_BYTES-1:0] rx_data;
  logic [FIDX_W-1:0]      rx_filter_idx;

  modport master (
    output rx_valid, rx_id_std, rx_id_ext, rx_ide, rx_remote_req, rx_dlc,
           rx_data, rx_filter_idx,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_id_std, rx_id_ext, rx_ide, rx_remote_req, rx_dlc,
           rx_data, rx_filter_idx,
    output rx_ready
  );
endinterface

// File: rtl/can_rx_frame_engine.sv
// can_rx_frame_engine
//   Classic-CAN receive engine: de-stuffing, CRC-15 check, form/stuff error
//   detection, acceptance filtering and a valid/ready holding register with
//   overrun indication. Fed by the bit-timing unit one sampled bit at a time.
//
//   clk, rst_n       clock, asynchronous active-low reset
//   i_sample_point   one-cycle strobe qualifying i_rx_bit_curr
//   i_rx_bit_curr    sampled bus bit (0 = dominant)
//   i_flt_id         per-entry {ide, id[28:0]}, entry i at [30i+29:30i]
//   i_flt_mask       per-entry compare mask (1 = compare)
//   i_flt_en         per-entry enable; all zero = accept all
//   rx_if            held-frame delivery interface (master side)
//   o_rx_overrun     pulse: accepted frame dropped because the holder was full
//   o_err_stuff      pulse: stuff error
//   o_err_crc        pulse: CRC mismatch
//   o_err_form       pulse: form error
module can_rx_frame_engine #(
  parameter int MAX_BYTES   = 8,
  parameter int NUM_FILTERS = 4,
  parameter int IDLE_BITS   = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_sample_point,
  input  logic                     i_rx_bit_curr,
  input  logic [NUM_FILTERS*30-1:0] i_flt_id,
  input  logic [NUM_FILTERS*30-1:0] i_flt_mask,
  input  logic [NUM_FILTERS-1:0]   i_flt_en,
  can_rx_frame_engine_if.master    rx_if,
  output logic                     o_rx_overrun,
  output logic                     o_err_stuff,
  output logic                     o_err_crc,
  output logic                     o_err_form
);
  localparam int FIDX_W = $clog2(NUM_FILTERS) + 1;
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  typedef enum logic [4:0] {
    WAIT_IDLE, IDLE, ID_STD, RTR1, IDE, ID_EXT, RTR2, R1, R0, DLC, DATA,
    CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS, ERROR
  } state_t;

  state_t                 r_state;
  logic [IDLE_W-1:0]      r_idleCnt;
  logic [6:0]             r_bitCnt;
  logic [6:0]             r_dataBits;
  logic [2:0]             r_runCnt;
  logic                   r_lastBit;
  logic [14:0]            r_crc;
  logic [14:0]            r_crcRx;
  logic [10:0]            r_idStd;
  logic [17:0]            r_idExt;
  logic                   r_ide;
  logic                   r_rtr;
  logic [3:0]             r_dlc;
  logic [8*MAX_BYTES-1:0] r_data;

  logic                   r_valid;
  logic [10:0]            r_hIdStd;
  logic [17:0]            r_hIdExt;
  logic                   r_hIde;
  logic                   r_hRtr;
  logic [3:0]             r_hDlc;
  logic [8*MAX_BYTES-1:0] r_hData;
  logic [FIDX_W-1:0]      r_hIdx;

  logic                   w_stuffZone;
  logic                   w_isStuff;
  logic                   w_crcFb;
  logic [14:0]            w_crcNext;
  logic [3:0]             w_dlcNext;
  logic [6:0]             w_dataBits;
  logic [29:0]            w_key;
  logic                   w_hit;
  logic [FIDX_W-1:0]      w_hitIdx;

  assign rx_if.rx_valid      = r_valid;
  assign rx_if.rx_id_std     = r_hIdStd;
  assign rx_if.rx_id_ext     = r_hIdExt;
  assign rx_if.rx_ide        = r_hIde;
  assign rx_if.rx_remote_req = r_hRtr;
  assign rx_if.rx_dlc        = r_hDlc;
  assign rx_if.rx_data       = r_hData;
  assign rx_if.rx_filter_idx = r_hIdx;

  // A stuff bit may also follow the last CRC bit, so CRC_DEL is checked for a
  // pending stuff bit before it is treated as the delimiter.
  assign w_stuffZone = r_state inside {ID_STD, RTR1, IDE, ID_EXT, RTR2, R1, R0, DLC, DATA, CRC};
  assign w_isStuff   = (w_stuffZone || r_state == CRC_DEL) && (r_runCnt == 3'd5);

  assign w_crcFb    = i_rx_bit_curr ^ r_crc[14];
  assign w_crcNext  = {r_crc[13:0], 1'b0} ^ (w_crcFb ? 15'h4599 : 15'h0000);
  assign w_dlcNext  = {r_dlc[2:0], i_rx_bit_curr};
  assign w_dataBits = (w_dlcNext > 4'd8) ? 7'd64 : {w_dlcNext, 3'b000};

  // r_idExt is cleared at SOF, so it is already 0 for base frames.
  assign w_key = {r_ide, r_idStd, r_idExt};

  // Scan downwards so the lowest matching entry wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (i_flt_en[i] && (((w_key ^ i_flt_id[30*i +: 30]) & i_flt_mask[30*i +: 30]) == 30'd0)) begin
        w_hit    = 1'b1;
        w_hitIdx = FIDX_W'(i);
      end
    end
    if (i_flt_en == '0) begin
      w_hit    = 1'b1;
      w_hitIdx = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_IDLE;
      r_idleCnt    <= '0;
      r_bitCnt     <= '0;
      r_dataBits   <= '0;
      r_runCnt     <= '0;
      r_lastBit    <= 1'b0;
      r_crc        <= '0;
      r_crcRx      <= '0;
      r_idStd      <= '0;
      r_idExt      <= '0;
      r_ide        <= 1'b0;
      r_rtr        <= 1'b0;
      r_dlc        <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_hIdStd     <= '0;
      r_hIdExt     <= '0;
      r_hIde       <= 1'b0;
      r_hRtr       <= 1'b0;
      r_hDlc       <= '0;
      r_hData      <= '0;
      r_hIdx       <= '0;
      o_rx_overrun <= 1'b0;
      o_err_stuff  <= 1'b0;
      o_err_crc    <= 1'b0;
      o_err_form   <= 1'b0;
    end else begin
      o_rx_overrun <= 1'b0;
      o_err_stuff  <= 1'b0;
      o_err_crc    <= 1'b0;
      o_err_form   <= 1'b0;
      // Consumer handshake; a load later in this block overrides the clear.
      if (r_valid && rx_if.rx_ready) r_valid <= 1'b0;

      if (r_state == ERROR) begin
        r_state   <= WAIT_IDLE;
        r_idleCnt <= '0;
      end else if (i_sample_point) begin
        if (w_isStuff) begin
          if (i_rx_bit_curr == r_lastBit) begin
            o_err_stuff <= 1'b1;
            r_state     <= ERROR;
          end else begin
            r_runCnt  <= 3'd1;
            r_lastBit <= i_rx_bit_curr;
          end
        end else begin
          if (w_stuffZone) begin
            r_runCnt  <= (i_rx_bit_curr == r_lastBit) ? r_runCnt + 3'd1 : 3'd1;
            r_lastBit <= i_rx_bit_curr;
            // The CRC covers SOF through data; SOF is 0 and leaves a zero CRC unchanged.
            if (r_state != CRC) r_crc <= w_crcNext;
          end
          case (r_state)
            WAIT_IDLE: begin
              if (!i_rx_bit_curr) r_idleCnt <= '0;
              else if (r_idleCnt == IDLE_W'(IDLE_BITS - 1)) begin
                r_state   <= IDLE;
                r_idleCnt <= '0;
              end else r_idleCnt <= r_idleCnt + IDLE_W'(1);
            end
            IDLE: if (!i_rx_bit_curr) begin
              r_state   <= ID_STD;
              r_bitCnt  <= '0;
              r_runCnt  <= 3'd1;
              r_lastBit <= 1'b0;
              r_crc     <= '0;
              r_idExt   <= '0;
              r_ide     <= 1'b0;
              r_rtr     <= 1'b0;
              r_dlc     <= '0;
              r_data    <= '0;
            end
            ID_STD: begin
              r_idStd <= {r_idStd[9:0], i_rx_bit_curr};
              if (r_bitCnt == 7'd10) begin
                r_state  <= RTR1;
                r_bitCnt <= '0;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            RTR1: begin
              r_rtr   <= i_rx_bit_curr;
              r_state <= IDE;
            end
            IDE: begin
              r_ide   <= i_rx_bit_curr;
              r_state <= i_rx_bit_curr ? ID_EXT : R0;
            end
            ID_EXT: begin
              r_idExt <= {r_idExt[16:0], i_rx_bit_curr};
              if (r_bitCnt == 7'd17) begin
                r_state  <= RTR2;
                r_bitCnt <= '0;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            // In extended frames the bit after ID_STD was SRR; the real RTR is here.
            RTR2: begin
              r_rtr   <= i_rx_bit_curr;
              r_state <= R1;
            end
            R1: r_state <= R0;
            R0: begin
              r_state  <= DLC;
              r_bitCnt <= '0;
            end
            DLC: begin
              r_dlc <= w_dlcNext;
              if (r_bitCnt == 7'd3) begin
                r_bitCnt   <= '0;
                r_dataBits <= w_dataBits;
                r_state    <= (r_rtr || w_dlcNext == 4'd0) ? CRC : DATA;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            DATA: begin
              if (int'(r_bitCnt[5:3]) < MAX_BYTES)
                r_data[{r_bitCnt[5:3], 3'b000} +: 8] <= {r_data[{r_bitCnt[5:3], 3'b000} +: 7], i_rx_bit_curr};
              if (r_bitCnt == r_dataBits - 7'd1) begin
                r_state  <= CRC;
                r_bitCnt <= '0;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            CRC: begin
              r_crcRx <= {r_crcRx[13:0], i_rx_bit_curr};
              if (r_bitCnt == 7'd14) begin
                r_state  <= CRC_DEL;
                r_bitCnt <= '0;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            CRC_DEL: begin
              if (r_crcRx != r_crc) begin
                o_err_crc <= 1'b1;
                r_state   <= ERROR;
              end else if (!i_rx_bit_curr) begin
                o_err_form <= 1'b1;
                r_state    <= ERROR;
              end else r_state <= ACK;
            end
            ACK: r_state <= ACK_DEL;
            ACK_DEL: begin
              if (!i_rx_bit_curr) begin
                o_err_form <= 1'b1;
                r_state    <= ERROR;
              end else begin
                r_state  <= EOF;
                r_bitCnt <= '0;
              end
            end
            EOF: begin
              if (!i_rx_bit_curr) begin
                o_err_form <= 1'b1;
                r_state    <= ERROR;
              end else if (r_bitCnt == 7'd6) begin
                r_state  <= IFS;
                r_bitCnt <= '0;
                if (w_hit) begin
                  if (!r_valid || rx_if.rx_ready) begin
                    r_valid  <= 1'b1;
                    r_hIdStd <= r_idStd;
                    r_hIdExt <= r_idExt;
                    r_hIde   <= r_ide;
                    r_hRtr   <= r_rtr;
                    r_hDlc   <= r_dlc;
                    r_hData  <= r_data;
                    r_hIdx   <= w_hitIdx;
                  end else o_rx_overrun <= 1'b1;
                end
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            IFS: begin
              if (r_bitCnt == 7'd2) begin
                r_state  <= IDLE;
                r_bitCnt <= '0;
              end else r_bitCnt <= r_bitCnt + 7'd1;
            end
            default: r_state <= WAIT_IDLE;
          endcase
        end
      end
    end
  end
endmodule
